// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: bus event bundle, slave FSM states, ACK levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package i2c_pkg;

  // One-clk event pulses decoded from the synchronised scl/sda lines.
  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start;    // sda falls while scl is high (START or repeated START)
    logic stop;     // sda rises while scl is high
  } i2c_bus_evt_t;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RX_ADDR   = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_RX_PTR    = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_RX_DATA   = 4'd5,
    ST_DATA_ACK  = 4'd6,
    ST_TX_DATA   = 4'd7,
    ST_TX_ACK    = 4'd8,
    ST_WAIT_STOP = 4'd9
  } i2c_slave_state_t;

  // Bus level during the ninth clock of a byte.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// 3-FF synchroniser for scl/sda with scl edge and START/STOP event decode.
// Latency: events appear 2 clk after the pin change.
// Backpressure: none; events are single-clk pulses that must be consumed when seen.
//
// Ports: clk, rst_n (async active-low); scl, sda raw bus pins;
//        sda_lvl synchronised sda aligned with the events; evt event pulses.
`timescale 1ns/1ps
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         scl,
  input  logic         sda,
  output logic         sda_lvl,
  output i2c_bus_evt_t evt
);

  // Bit 0 is the newest sample; edges compare stages 1 (new) and 2 (old).
  logic [2:0] scl_sync;
  logic [2:0] sda_sync;

  // Reset to the idle-high bus level so reset release creates no false edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], scl};
      sda_sync <= {sda_sync[1:0], sda};
    end
  end

  assign sda_lvl      = sda_sync[1];
  assign evt.scl_rise =  scl_sync[1] & ~scl_sync[2];
  assign evt.scl_fall = ~scl_sync[1] &  scl_sync[2];
  assign evt.start    =  scl_sync[1] &  scl_sync[2] & ~sda_sync[1] &  sda_sync[2];
  assign evt.stop     =  scl_sync[1] &  scl_sync[2] &  sda_sync[1] & ~sda_sync[2];

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C register-file slave: NUM_REGS 8-bit registers behind an auto-incrementing pointer.
// Latency: bus reaction ~3 clk after each scl edge; wr_strobe 3 clk after the 8th data rise.
// Backpressure: none; the master owns scl and this slave never stretches the clock.
//
// Ports: clk, rst_n (async active-low); scl in; sda open-drain inout (0 or Z);
//        rd_data_in read-only sources (reg i = [8i+7:8i]); regs_out writable contents;
//        wr_strobe/wr_index write pulse and index; debug_addr_match; debug_state.
`timescale 1ns/1ps
module i2c_reg_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]          SLAVE_ADDR = 7'h55,
  parameter int                  NUM_REGS   = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  localparam int                 PTR_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl,
  inout  wire                   sda,
  input  logic [NUM_REGS*8-1:0] rd_data_in,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_index,
  output logic                  debug_addr_match,
  output logic [3:0]            debug_state
);

  localparam logic [7:0]       NUM_REGS_B = 8'(NUM_REGS);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_REGS - 1);

  i2c_bus_evt_t     evt;
  logic             sda_lvl;

  i2c_slave_state_t state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_oe_q, sda_oe_d;
  logic             addr_match_q, addr_match_d;
  logic             rw_q, rw_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0] wr_index_q, wr_index_d;
  logic             wr_en;

  logic [7:0]       regs_q [NUM_REGS];
  logic [7:0]       rd_src [NUM_REGS];
  logic [7:0]       byte_in;
  logic [PTR_W-1:0] ptr_inc;

  i2c_bus_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl     (scl),
    .sda     (sda),
    .sda_lvl (sda_lvl),
    .evt     (evt)
  );

  // Open drain: only ever pull low.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  // Byte as it stands once the bit on the current scl rise is shifted in.
  assign byte_in = {shift_q[6:0], sda_lvl};
  assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_src[i] = RO_MASK[i] ? rd_data_in[8*i +: 8] : regs_q[i];
    end
  end

  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_out[8*i +: 8] = regs_q[i];
    end
  end

  // The three ACK states share one scheme: bit_cnt 0 waits for the fall that
  // ends the 8th bit (start pulling low), bit_cnt 1 waits for the fall that
  // ends the 9th clock (release and move on).
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    ptr_d        = ptr_q;
    sda_oe_d     = sda_oe_q;
    addr_match_d = addr_match_q;
    rw_d         = rw_q;
    wr_en        = 1'b0;
    wr_strobe_d  = 1'b0;
    wr_index_d   = wr_index_q;

    if (evt.stop) begin
      state_d      = ST_IDLE;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
    end else if (evt.start) begin
      state_d      = ST_RX_ADDR;
      bit_cnt_d    = '0;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_RX_ADDR: if (evt.scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (byte_in[7:1] == SLAVE_ADDR) begin
              state_d      = ST_ADDR_ACK;
              addr_match_d = 1'b1;
              rw_d         = byte_in[0];
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end

        ST_ADDR_ACK: if (evt.scl_fall) begin
          if (bit_cnt_q == 4'd0) begin
            sda_oe_d  = 1'b1;
            bit_cnt_d = 4'd1;
          end else begin
            bit_cnt_d = '0;
            if (rw_q) begin
              // Same fall ends the ACK and presents the first data bit.
              state_d  = ST_TX_DATA;
              shift_d  = rd_src[ptr_q];
              sda_oe_d = ~rd_src[ptr_q][7];
            end else begin
              state_d  = ST_RX_PTR;
              sda_oe_d = 1'b0;
            end
          end
        end

        ST_RX_PTR: if (evt.scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            state_d   = ST_PTR_ACK;
          end
        end

        ST_PTR_ACK: if (evt.scl_fall) begin
          if (bit_cnt_q == 4'd0) begin
            // shift_q still holds the received pointer byte.
            if (shift_q < NUM_REGS_B) begin
              ptr_d     = shift_q[PTR_W-1:0];
              sda_oe_d  = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end else begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            state_d   = ST_RX_DATA;
          end
        end

        ST_RX_DATA: if (evt.scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            state_d   = ST_DATA_ACK;
            if (!RO_MASK[ptr_q]) begin
              wr_en       = 1'b1;
              wr_strobe_d = 1'b1;
              wr_index_d  = ptr_q;
            end
          end
        end

        ST_DATA_ACK: if (evt.scl_fall) begin
          if (bit_cnt_q == 4'd0) begin
            sda_oe_d  = 1'b1;
            bit_cnt_d = 4'd1;
          end else begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            ptr_d     = ptr_inc;
            state_d   = ST_RX_DATA;
          end
        end

        // bit_cnt counts rises already clocked out; each fall presents the next
        // bit, MSB first (~cnt[2:0] == 7 - cnt). A fall at count 0 only occurs
        // after a master ACK, where the first bit has not yet been presented.
        ST_TX_DATA: begin
          if (evt.scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (evt.scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_TX_ACK;
            end else begin
              sda_oe_d = ~shift_q[~bit_cnt_q[2:0]];
            end
          end
        end

        ST_TX_ACK: if (evt.scl_rise) begin
          if (sda_lvl == I2C_ACK) begin
            ptr_d     = ptr_inc;
            shift_d   = rd_src[ptr_inc];
            bit_cnt_d = '0;
            state_d   = ST_TX_DATA;
          end else begin
            state_d = ST_WAIT_STOP;
          end
        end

        ST_IDLE, ST_WAIT_STOP: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ptr_q        <= '0;
      sda_oe_q     <= 1'b0;
      addr_match_q <= 1'b0;
      rw_q         <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_index_q   <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      sda_oe_q     <= sda_oe_d;
      addr_match_q <= addr_match_d;
      rw_q         <= rw_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_index_q   <= wr_index_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[ptr_q] <= byte_in;
    end
  end

  assign wr_strobe        = wr_strobe_q;
  assign wr_index         = wr_index_q;
  assign debug_addr_match = addr_match_q;
  assign debug_state      = state_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
`timescale 1ns/1ps
module tb_i2c_reg_slave;

  localparam int Q = 100;  // quarter of an scl period, ns

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;   // master pulls sda low when set
  wire         sda;
  logic [31:0] rd_a = 32'h0;
  logic [31:0] rd_b = 32'h1122_335A;
  logic [31:0] regs_a, regs_b;
  logic        wr_strobe_a, wr_strobe_b;
  logic [1:0]  wr_index_a, wr_index_b;
  logic        am_a, am_b;
  logic [3:0]  st_a, st_b;

  int checks = 0;
  int failures = 0;
  int strobes_a = 0;
  int strobes_b = 0;
  logic [1:0] idx_a[$];

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  // Slave A: default address 0x55, all registers writable.
  i2c_reg_slave #(.SLAVE_ADDR(7'h55), .NUM_REGS(4), .RO_MASK(4'b0000)) dut_a (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda), .rd_data_in(rd_a),
    .regs_out(regs_a), .wr_strobe(wr_strobe_a), .wr_index(wr_index_a),
    .debug_addr_match(am_a), .debug_state(st_a)
  );

  // Slave B on the same bus: address 0x3C, register 0 read-only.
  i2c_reg_slave #(.SLAVE_ADDR(7'h3C), .NUM_REGS(4), .RO_MASK(4'b0001)) dut_b (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda), .rd_data_in(rd_b),
    .regs_out(regs_b), .wr_strobe(wr_strobe_b), .wr_index(wr_index_b),
    .debug_addr_match(am_b), .debug_state(st_b)
  );

  always @(negedge clk) begin
    if (wr_strobe_a) begin
      strobes_a++;
      idx_a.push_back(wr_index_a);
    end
    if (wr_strobe_b) strobes_b++;
  end

  // ---------------- bus master ----------------
  task automatic bus_start();
    m_low = 1'b0; #(Q); scl = 1'b1; #(Q); m_low = 1'b1; #(Q); scl = 1'b0; #(Q);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #(Q); scl = 1'b1; #(Q); m_low = 1'b0; #(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; #(Q); scl = 1'b1; #(2*Q); scl = 1'b0; #(Q);
    end
    m_low = 1'b0; #(Q); scl = 1'b1; #(Q); ack = sda; #(Q); scl = 1'b0; #(Q);
  endtask

  task automatic recv_byte(input logic ack_it, output logic [7:0] b);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #(Q); scl = 1'b1; #(Q); b[i] = sda; #(Q); scl = 1'b0; #(Q);
    end
    m_low = ack_it; #(Q); scl = 1'b1; #(2*Q); scl = 1'b0; #(Q); m_low = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; #(50); rst_n = 1'b1; #(50);
    checks++; if (regs_a !== 32'h0) begin failures++; $display("FAIL rst_regs got=%h exp=00000000", regs_a); end
    checks++; if (wr_strobe_a !== 1'b0) begin failures++; $display("FAIL rst_strobe got=%b exp=0", wr_strobe_a); end
    checks++; if (wr_index_a !== 2'd0) begin failures++; $display("FAIL rst_index got=%0d exp=0", wr_index_a); end
    checks++; if (am_a !== 1'b0) begin failures++; $display("FAIL rst_addr_match got=%b exp=0", am_a); end
    checks++; if (st_a !== 4'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", st_a); end
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL rst_sda got=%b exp=1", sda); end
  endtask

  task automatic test_write_burst();
    logic a;
    logic [3:0] nacks;
    int s0;
    logic [3:0] got_idx;
    s0 = strobes_a; idx_a.delete();
    bus_start();
    send_byte(8'hAA, a); nacks[3] = a;
    checks++; if (am_a !== 1'b1) begin failures++; $display("FAIL wb_addr_match got=%b exp=1", am_a); end
    send_byte(8'h01, a); nacks[2] = a;
    send_byte(8'h12, a); nacks[1] = a;
    send_byte(8'h34, a); nacks[0] = a;
    bus_stop();
    checks++; if (nacks !== 4'b0000) begin failures++; $display("FAIL wb_acks got=%b exp=0000", nacks); end
    checks++; if (regs_a !== 32'h0034_1200) begin failures++; $display("FAIL wb_regs got=%h exp=00341200", regs_a); end
    checks++; if (strobes_a - s0 != 2) begin failures++; $display("FAIL wb_strobes got=%0d exp=2", strobes_a - s0); end
    got_idx = (idx_a.size() == 2) ? {idx_a[0], idx_a[1]} : 4'bxxxx;
    checks++; if (got_idx !== 4'b0110) begin failures++; $display("FAIL wb_index got=%b exp=0110", got_idx); end
    checks++; if (am_a !== 1'b0) begin failures++; $display("FAIL wb_match_after_stop got=%b exp=0", am_a); end
    checks++; if (st_a !== 4'd0) begin failures++; $display("FAIL wb_state_after_stop got=%0d exp=0", st_a); end
  endtask

  task automatic test_wrap();
    logic a;
    logic [3:0] nacks;
    logic [3:0] got_idx;
    idx_a.delete();
    bus_start();
    send_byte(8'hAA, a); nacks[3] = a;
    send_byte(8'h03, a); nacks[2] = a;
    send_byte(8'hA0, a); nacks[1] = a;
    send_byte(8'hA1, a); nacks[0] = a;
    bus_stop();
    checks++; if (nacks !== 4'b0000) begin failures++; $display("FAIL wrap_acks got=%b exp=0000", nacks); end
    checks++; if (regs_a !== 32'hA034_12A1) begin failures++; $display("FAIL wrap_regs got=%h exp=a03412a1", regs_a); end
    got_idx = (idx_a.size() == 2) ? {idx_a[0], idx_a[1]} : 4'bxxxx;
    checks++; if (got_idx !== 4'b1100) begin failures++; $display("FAIL wrap_index got=%b exp=1100", got_idx); end
  endtask

  task automatic test_random_read();
    logic a;
    logic [2:0] nacks;
    logic [7:0] d0, d1;
    int s0;
    s0 = strobes_a;
    bus_start();
    send_byte(8'hAA, a); nacks[2] = a;
    send_byte(8'h02, a); nacks[1] = a;
    bus_start();
    send_byte(8'hAB, a); nacks[0] = a;
    recv_byte(1'b1, d0);
    recv_byte(1'b0, d1);
    checks++; if (nacks !== 3'b000) begin failures++; $display("FAIL rr_acks got=%b exp=000", nacks); end
    checks++; if (d0 !== 8'h34) begin failures++; $display("FAIL rr_byte0 got=%h exp=34", d0); end
    checks++; if (d1 !== 8'hA0) begin failures++; $display("FAIL rr_byte1 got=%h exp=a0", d1); end
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL rr_sda_released got=%b exp=1", sda); end
    checks++; if (st_a !== 4'd9) begin failures++; $display("FAIL rr_wait_stop got=%0d exp=9", st_a); end
    bus_stop();
    checks++; if (st_a !== 4'd0) begin failures++; $display("FAIL rr_idle got=%0d exp=0", st_a); end
    checks++; if (strobes_a != s0) begin failures++; $display("FAIL rr_no_strobe got=%0d exp=%0d", strobes_a, s0); end
  endtask

  task automatic test_ro_register();
    logic a;
    logic [5:0] nacks;
    logic [7:0] d;
    int sa0, sb0;
    sa0 = strobes_a; sb0 = strobes_b;
    bus_start();
    send_byte(8'h78, a); nacks[5] = a;
    send_byte(8'h00, a); nacks[4] = a;
    send_byte(8'hFF, a); nacks[3] = a;
    bus_stop();
    checks++; if (strobes_b != sb0) begin failures++; $display("FAIL ro_no_strobe got=%0d exp=%0d", strobes_b, sb0); end
    checks++; if (regs_b !== 32'h0) begin failures++; $display("FAIL ro_regs got=%h exp=00000000", regs_b); end
    bus_start();
    send_byte(8'h78, a); nacks[2] = a;
    send_byte(8'h00, a); nacks[1] = a;
    bus_start();
    send_byte(8'h79, a); nacks[0] = a;
    rd_b = 32'h1122_33C3;   // byte already loaded must not change
    recv_byte(1'b0, d);
    bus_stop();
    checks++; if (nacks !== 6'b0) begin failures++; $display("FAIL ro_acks got=%b exp=000000", nacks); end
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL ro_read got=%h exp=5a", d); end
    bus_start();
    send_byte(8'h78, a);
    send_byte(8'h00, a);
    bus_start();
    send_byte(8'h79, a);
    recv_byte(1'b0, d);
    bus_stop();
    checks++; if (d !== 8'hC3) begin failures++; $display("FAIL ro_read_new got=%h exp=c3", d); end
    checks++; if (regs_a !== 32'hA034_12A1) begin failures++; $display("FAIL ro_other_regs got=%h exp=a03412a1", regs_a); end
    checks++; if (strobes_a != sa0) begin failures++; $display("FAIL ro_other_strobe got=%0d exp=%0d", strobes_a, sa0); end
  endtask

  task automatic test_bad_addr_ptr();
    logic a;
    logic [7:0] d;
    int s0;
    s0 = strobes_a;
    bus_start();
    send_byte(8'hA8, a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL bad_addr_nack got=%b exp=1", a); end
    checks++; if (st_a !== 4'd9) begin failures++; $display("FAIL bad_addr_state got=%0d exp=9", st_a); end
    checks++; if (am_a !== 1'b0) begin failures++; $display("FAIL bad_addr_match got=%b exp=0", am_a); end
    send_byte(8'h00, a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL bad_addr_data_nack got=%b exp=1", a); end
    bus_stop();
    bus_start();
    send_byte(8'hAA, a);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL bad_ptr_addr_ack got=%b exp=0", a); end
    send_byte(8'h07, a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL bad_ptr_nack got=%b exp=1", a); end
    checks++; if (st_a !== 4'd9) begin failures++; $display("FAIL bad_ptr_state got=%0d exp=9", st_a); end
    send_byte(8'h99, a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL bad_ptr_data_nack got=%b exp=1", a); end
    bus_stop();
    checks++; if (regs_a !== 32'hA034_12A1) begin failures++; $display("FAIL bad_regs got=%h exp=a03412a1", regs_a); end
    checks++; if (strobes_a != s0) begin failures++; $display("FAIL bad_strobe got=%0d exp=%0d", strobes_a, s0); end
    // Pointer was 3 before and must be untouched: a plain read returns reg3.
    bus_start();
    send_byte(8'hAB, a);
    recv_byte(1'b0, d);
    bus_stop();
    checks++; if (d !== 8'hA0) begin failures++; $display("FAIL bad_ptr_kept got=%h exp=a0", d); end
  endtask

  task automatic test_reset_mid_read();
    logic a;
    logic [2:0] nacks;
    bus_start();
    send_byte(8'hAA, a);
    send_byte(8'h02, a);
    bus_start();
    send_byte(8'hAB, a);
    // reg2 = 0x34, MSB 0: slave is now pulling sda low.
    checks++; if (sda !== 1'b0) begin failures++; $display("FAIL mr_driving got=%b exp=0", sda); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL mr_sda_release got=%b exp=1", sda); end
    checks++; if (regs_a !== 32'h0) begin failures++; $display("FAIL mr_regs got=%h exp=00000000", regs_a); end
    checks++; if (st_a !== 4'd0) begin failures++; $display("FAIL mr_state got=%0d exp=0", st_a); end
    rst_n = 1'b1;
    #(Q);
    bus_stop();
    bus_start();
    send_byte(8'hAA, a); nacks[2] = a;
    send_byte(8'h00, a); nacks[1] = a;
    send_byte(8'h77, a); nacks[0] = a;
    bus_stop();
    checks++; if (nacks !== 3'b000) begin failures++; $display("FAIL mr_post_acks got=%b exp=000", nacks); end
    checks++; if (regs_a !== 32'h0000_0077) begin failures++; $display("FAIL mr_post_regs got=%h exp=00000077", regs_a); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_wrap();
    test_random_read();
    test_ro_register();
    test_bad_addr_ptr();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
